// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared types and constants for the LEGv8 multicycle control unit
package legv8_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        FAULT
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_R,
        CLS_ADDI,
        CLS_SUBI,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_CBNZ,
        CLS_B,
        CLS_ILLEGAL
    } opclass_t;

    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_ADDI = 11'b100_1000_100?;
    localparam logic [10:0] OP_SUBI = 11'b110_1000_100?;
    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_CBZ  = 11'b101_1010_0???;
    localparam logic [10:0] OP_CBNZ = 11'b101_1010_1???;
    localparam logic [10:0] OP_B    = 11'b000_101?_????;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_ILLEGAL  = 2'b01;
    localparam logic [1:0] FC_IMEM_TMO = 2'b10;
    localparam logic [1:0] FC_DMEM_TMO = 2'b11;

    // Classes whose second read register comes from Rt rather than Rm.
    function automatic logic uses_reg2loc(input opclass_t c);
        return (c == CLS_STUR) || (c == CLS_CBZ) || (c == CLS_CBNZ);
    endfunction

endpackage

// File: rtl/legv8_mc_ctrl_if.sv
// rtl/legv8_mc_ctrl_if.sv - instruction/data memory request/ready handshake
interface legv8_mc_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/legv8_opclass.sv
// rtl/legv8_opclass.sv - combinational Op[10:0] to instruction class decode
module legv8_opclass
    import legv8_pkg::*;
(
    input  logic [10:0] op,
    output opclass_t    cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        casez (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = CLS_R;
            OP_ADDI: cls = CLS_ADDI;
            OP_SUBI: cls = CLS_SUBI;
            OP_LDUR: cls = CLS_LDUR;
            OP_STUR: cls = CLS_STUR;
            OP_CBZ:  cls = CLS_CBZ;
            OP_CBNZ: cls = CLS_CBNZ;
            OP_B:    cls = CLS_B;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// rtl/legv8_mc_ctrl.sv - LEGv8 multicycle control FSM with memory watchdog and retire counter
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [10:0]       Op,
    input  logic              Zero,
    legv8_mc_ctrl_if.master   mem,
    output logic              IRWrite,
    output logic              PCInc,
    output logic              PCBranch,
    output logic              Reg2Loc,
    output logic              ALUSrc,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [1:0]        ALUOp,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t     state;
    opclass_t   cls;
    opclass_t   op_cls;
    logic [15:0] wcnt;
    logic       wd_expire;

    legv8_opclass u_opclass (
        .op  (Op),
        .cls (op_cls)
    );

    // The count only advances on low-ready cycles, so hitting the last slot with ready still low is the timeout.
    assign wd_expire = (TIMEOUT != 0) && (wcnt == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            cls        <= CLS_NOP;
            wcnt       <= '0;
            retired    <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            case (state)
                FETCH: begin
                    if (mem.imem_ready) begin
                        state <= DECODE;
                    end else if (wd_expire) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_IMEM_TMO;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                DECODE: begin
                    cls <= op_cls;
                    if (op_cls == CLS_ILLEGAL) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_ILLEGAL;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (cls)
                        CLS_R, CLS_ADDI, CLS_SUBI: state <= WB;
                        CLS_LDUR, CLS_STUR: begin
                            state <= MEM;
                            wcnt  <= '0;
                        end
                        default: begin
                            state   <= FETCH;
                            wcnt    <= '0;
                            retired <= retired + 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    if (mem.dmem_ready) begin
                        if (cls == CLS_LDUR) begin
                            state <= WB;
                        end else begin
                            state   <= FETCH;
                            wcnt    <= '0;
                            retired <= retired + 1'b1;
                        end
                    end else if (wd_expire) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_DMEM_TMO;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                WB: begin
                    state   <= FETCH;
                    wcnt    <= '0;
                    retired <= retired + 1'b1;
                end
                default: state <= FAULT;
            endcase
        end
    end

    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        IRWrite      = 1'b0;
        PCInc        = 1'b0;
        PCBranch     = 1'b0;
        Reg2Loc      = 1'b0;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        ALUOp        = ALUOP_ADD;
        if (reset_n) begin
            case (state)
                FETCH: begin
                    mem.imem_req = 1'b1;
                    IRWrite      = mem.imem_ready;
                    PCInc        = mem.imem_ready;
                end
                // Register operands are read while decoding, before the class register is loaded.
                DECODE: Reg2Loc = uses_reg2loc(op_cls);
                EXEC: begin
                    case (cls)
                        CLS_R: ALUOp = ALUOP_RTYPE;
                        CLS_ADDI, CLS_SUBI: begin
                            ALUSrc = 1'b1;
                            ALUOp  = ALUOP_IMM;
                        end
                        CLS_LDUR: ALUSrc = 1'b1;
                        CLS_STUR: begin
                            ALUSrc  = 1'b1;
                            Reg2Loc = 1'b1;
                        end
                        CLS_CBZ: begin
                            Reg2Loc  = 1'b1;
                            ALUOp    = ALUOP_PASSB;
                            PCBranch = Zero;
                        end
                        CLS_CBNZ: begin
                            Reg2Loc  = 1'b1;
                            ALUOp    = ALUOP_PASSB;
                            PCBranch = ~Zero;
                        end
                        CLS_B:   PCBranch = 1'b1;
                        default: ALUOp = ALUOP_ADD;
                    endcase
                end
                MEM: begin
                    mem.dmem_req = 1'b1;
                    MemRead      = (cls == CLS_LDUR);
                    MemWrite     = (cls == CLS_STUR);
                end
                WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls == CLS_LDUR);
                end
                default: ALUOp = ALUOP_ADD;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// tb/tb_legv8_mc_ctrl.sv - directed self-checking bench for legv8_mc_ctrl
module tb_legv8_mc_ctrl;

    localparam int TMO = 4;

    localparam logic [15:0] E_IREQ   = 16'h8000;
    localparam logic [15:0] E_DREQ   = 16'h4000;
    localparam logic [15:0] E_IRW    = 16'h2000;
    localparam logic [15:0] E_PCI    = 16'h1000;
    localparam logic [15:0] E_PCB    = 16'h0800;
    localparam logic [15:0] E_R2L    = 16'h0400;
    localparam logic [15:0] E_ALUSRC = 16'h0200;
    localparam logic [15:0] E_M2R    = 16'h0100;
    localparam logic [15:0] E_RW     = 16'h0080;
    localparam logic [15:0] E_MR     = 16'h0040;
    localparam logic [15:0] E_MW     = 16'h0020;
    localparam logic [15:0] E_ALU10  = 16'h0010;
    localparam logic [15:0] E_ALU01  = 16'h0008;
    localparam logic [15:0] E_ALU11  = 16'h0018;
    localparam logic [15:0] E_FLT    = 16'h0004;

    localparam int K_R = 0, K_ADDI = 1, K_SUBI = 2, K_LDUR = 3, K_STUR = 4;
    localparam int K_CBZ = 5, K_CBNZ = 6, K_B = 7, K_ILL = 8;

    localparam logic [10:0] C_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] C_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] C_AND  = 11'b100_0101_0000;
    localparam logic [10:0] C_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] C_ADDI = 11'b100_1000_1000;
    localparam logic [10:0] C_SUBI = 11'b110_1000_1001;
    localparam logic [10:0] C_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] C_STUR = 11'b111_1100_0000;
    localparam logic [10:0] C_CBZ  = 11'b101_1010_0000;
    localparam logic [10:0] C_CBNZ = 11'b101_1010_1111;
    localparam logic [10:0] C_B0   = 11'b000_1010_0000;
    localparam logic [10:0] C_B1   = 11'b000_1011_1111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] Op = '0;
    logic        Zero = 1'b0;
    logic        IRWrite, PCInc, PCBranch, Reg2Loc, ALUSrc, MemtoReg;
    logic        RegWrite, MemRead, MemWrite, fault;
    logic [1:0]  ALUOp, fault_code;
    logic [15:0] retired;
    logic [15:0] act;

    legv8_mc_ctrl_if mif ();

    legv8_mc_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Op         (Op),
        .Zero       (Zero),
        .mem        (mif),
        .IRWrite    (IRWrite),
        .PCInc      (PCInc),
        .PCBranch   (PCBranch),
        .Reg2Loc    (Reg2Loc),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUOp      (ALUOp),
        .fault      (fault),
        .fault_code (fault_code),
        .retired    (retired)
    );

    assign act = {mif.imem_req, mif.dmem_req, IRWrite, PCInc, PCBranch, Reg2Loc, ALUSrc,
                  MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, fault, fault_code};

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        int          r;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   exp_ret = 0;
    int   tag = 0;
    int   nc;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h", name, a, e);
        end
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("ctl_cyc%0d", e.tag), 32'(act), 32'(e.v));
            check($sformatf("retired_cyc%0d", e.tag), 32'(retired), 32'(e.r));
        end
    end

    task automatic step(input logic ir, input logic dr, input logic [15:0] v);
        exp_t e;
        mif.imem_ready = ir;
        mif.dmem_ready = dr;
        e.v = v;
        e.r = exp_ret;
        e.tag = tag;
        exp_q.push_back(e);
        tag++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exec_vec(input int k, input logic z);
        case (k)
            K_R:            return E_ALU10;
            K_ADDI, K_SUBI: return E_ALUSRC | E_ALU11;
            K_LDUR:         return E_ALUSRC;
            K_STUR:         return E_ALUSRC | E_R2L;
            K_CBZ:          return E_R2L | E_ALU01 | (z ? E_PCB : 16'h0);
            K_CBNZ:         return E_R2L | E_ALU01 | (z ? 16'h0 : E_PCB);
            K_B:            return E_PCB;
            default:        return 16'h0;
        endcase
    endfunction

    task automatic fault_run(input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, E_FLT | {14'h0, code});
    endtask

    task automatic run_instr(input logic [10:0] op, input int k, input logic z,
                             input int iw, input int dw, input logic noise, output int ncyc);
        int n;
        logic [15:0] mv;
        ncyc = 0;
        Op = op;
        Zero = z;
        n = (iw >= TMO) ? TMO : iw;
        for (int i = 0; i < n; i++) begin step(1'b0, noise, E_IREQ); ncyc++; end
        if (iw >= TMO) begin fault_run(2'b10, 5); return; end
        step(1'b1, noise, E_IREQ | E_IRW | E_PCI); ncyc++;
        step(noise, noise, (k == K_STUR || k == K_CBZ || k == K_CBNZ) ? E_R2L : 16'h0); ncyc++;
        if (k == K_ILL) begin fault_run(2'b01, 20); return; end
        step(noise, noise, exec_vec(k, z)); ncyc++;
        if (k == K_LDUR || k == K_STUR) begin
            mv = (k == K_LDUR) ? (E_DREQ | E_MR) : (E_DREQ | E_MW);
            n = (dw >= TMO) ? TMO : dw;
            for (int i = 0; i < n; i++) begin step(noise, 1'b0, mv); ncyc++; end
            if (dw >= TMO) begin fault_run(2'b11, 5); return; end
            step(noise, 1'b1, mv); ncyc++;
        end
        if (k == K_R || k == K_ADDI || k == K_SUBI || k == K_LDUR) begin
            step(noise, noise, E_RW | ((k == K_LDUR) ? E_M2R : 16'h0)); ncyc++;
        end
        exp_ret++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("reset_ctl", 32'(act), 32'h0);
        check("reset_retired", 32'(retired), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_ret = 0;
    endtask

    initial begin
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        #2;
        check("por_ctl", 32'(act), 32'h0);
        check("por_retired", 32'(retired), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_instr(C_ADD, K_R, 1'b0, 0, 0, 1'b0, nc);
        check("add_cycles", 32'(nc), 32'd4);
        check("add_retired", 32'(retired), 32'd1);
        run_instr(C_SUB, K_R, 1'b0, 2, 0, 1'b0, nc);
        check("sub_wait_cycles", 32'(nc), 32'd6);
        run_instr(C_AND, K_R, 1'b1, 0, 0, 1'b1, nc);
        run_instr(C_ORR, K_R, 1'b0, 1, 0, 1'b1, nc);
        run_instr(C_ADDI, K_ADDI, 1'b0, 0, 0, 1'b0, nc);
        run_instr(C_SUBI, K_SUBI, 1'b0, 0, 0, 1'b1, nc);
        run_instr(C_LDUR, K_LDUR, 1'b0, 0, 3, 1'b0, nc);
        check("ldur_cycles", 32'(nc), 32'd8);
        run_instr(C_STUR, K_STUR, 1'b0, 0, 1, 1'b1, nc);
        check("stur_cycles", 32'(nc), 32'd5);
        run_instr(C_CBZ, K_CBZ, 1'b1, 0, 0, 1'b0, nc);
        check("cbz_cycles", 32'(nc), 32'd3);
        run_instr(C_CBNZ, K_CBNZ, 1'b1, 0, 0, 1'b0, nc);
        run_instr(C_CBZ, K_CBZ, 1'b0, 0, 0, 1'b0, nc);
        run_instr(C_CBNZ, K_CBNZ, 1'b0, 0, 0, 1'b1, nc);
        run_instr(C_B0, K_B, 1'b0, 0, 0, 1'b0, nc);
        run_instr(C_B1, K_B, 1'b1, 0, 0, 1'b1, nc);
        run_instr(C_ADD, K_R, 1'b0, 3, 0, 1'b0, nc);
        check("imem_late_ready_cycles", 32'(nc), 32'd7);
        check("retired_total", 32'(retired), 32'd15);

        run_instr(11'h7FF, K_ILL, 1'b0, 0, 0, 1'b0, nc);
        check("illegal_code", 32'(fault_code), 32'h1);
        check("illegal_fault", 32'(fault), 32'h1);
        do_reset();

        run_instr(C_ADD, K_R, 1'b0, 10, 0, 1'b0, nc);
        check("imem_tmo_code", 32'(fault_code), 32'h2);
        do_reset();

        run_instr(C_STUR, K_STUR, 1'b0, 0, 10, 1'b0, nc);
        check("dmem_tmo_code", 32'(fault_code), 32'h3);
        do_reset();

        run_instr(C_B0, K_B, 1'b0, 0, 0, 1'b0, nc);
        Op = C_STUR;
        step(1'b1, 1'b0, E_IREQ | E_IRW | E_PCI);
        step(1'b0, 1'b0, E_R2L);
        step(1'b0, 1'b0, E_ALUSRC | E_R2L);
        step(1'b0, 1'b0, E_DREQ | E_MW);
        check("mw_before_reset", 32'(MemWrite), 32'h1);
        check("retired_before_reset", 32'(retired), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mw_async_drop", 32'(MemWrite), 32'h0);
        check("ctl_async_drop", 32'(act), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_ret = 0;
        check("retired_after_reset", 32'(retired), 32'd0);
        run_instr(C_ADD, K_R, 1'b0, 0, 0, 1'b0, nc);
        check("resume_retired", 32'(retired), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
